// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the decoder/datapath and the hazard controller.
// The decoder side (master) presents the ID-stage instruction fields and
// consumes the stall, bubble and forwarding selects; the controller side
// (slave) does the opposite.
interface pipeline_hazard_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    // ID-stage instruction fields
    logic [4:0]             rS1;
    logic [4:0]             rS2;
    logic                   idUsesS1;
    logic                   idUsesS2;
    logic [4:0]             idRw;
    logic                   idRegWr;
    logic                   idLoad;
    logic                   idStore;
    logic                   idBranch;
    logic                   idHalt;

    // Forwarding selects (ID compare and values latched into ID/EX)
    logic                   exMemIdA;
    logic                   exMemIdB;
    logic                   exMemExA;
    logic                   exMemExB;
    logic                   memWbExA;
    logic                   memWbExB;
    logic                   memWbMem;

    // Pipeline flow control and status
    logic                   ifIdWrIn;
    logic                   pcWr;
    logic                   bubble;
    logic                   endProgram;
    logic [STALL_CNT_W-1:0] stallCycles;

    modport master (
        output rS1, rS2, idUsesS1, idUsesS2, idRw, idRegWr,
               idLoad, idStore, idBranch, idHalt,
        input  exMemIdA, exMemIdB, exMemExA, exMemExB,
               memWbExA, memWbExB, memWbMem,
               ifIdWrIn, pcWr, bubble, endProgram, stallCycles
    );

    modport slave (
        input  rS1, rS2, idUsesS1, idUsesS2, idRw, idRegWr,
               idLoad, idStore, idBranch, idHalt,
        output exMemIdA, exMemIdB, exMemExA, exMemExB,
               memWbExA, memWbExB, memWbMem,
               ifIdWrIn, pcWr, bubble, endProgram, stallCycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for the IF/ID/EX/MEM/WB pipeline.
// Tracks the destination/write/load flags of the instructions in EX, MEM and
// WB, detects RAW hazards against the ID-stage sources, produces the
// forwarding selects that ID/EX latches, stalls IF/ID and the PC while
// injecting bubbles, and sequences the end-of-program drain.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);

    // Drain counter only has to hold DRAIN_CYCLES-1.
    localparam int               CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A producer only matters when it really writes a non-zero register.
    function automatic logic regMatch(
        input logic [4:0] src,
        input logic       used,
        input logic [4:0] rw,
        input logic       regWr
    );
        return used && regWr && (rw != 5'd0) && (src == rw);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4:0]             exRw_r;
    logic                   exRegWr_r;
    logic                   exLoad_r;
    logic [4:0]             memRw_r;
    logic                   memRegWr_r;
    logic                   memLoad_r;
    logic [4:0]             wbRw_r;
    logic                   wbRegWr_r;

    state_t                 state_r;
    logic [CNT_W-1:0]       drainCnt_r;
    logic                   endProgram_r;
    logic [STALL_CNT_W-1:0] stallCycles_r;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic hitEx1_s;
    logic hitEx2_s;
    logic hitMem1_s;
    logic hitMem2_s;
    logic hitWb1_s;
    logic hitWb2_s;

    logic loadUse_s;
    logic branchEx_s;
    logic branchMemLoad_s;
    logic wbOnly_s;
    logic hazard_s;
    logic run_s;
    logic stall_s;
    logic flowing_s;
    logic acceptHalt_s;

    assign hitEx1_s  = regMatch(hz.rS1, hz.idUsesS1, exRw_r,  exRegWr_r);
    assign hitEx2_s  = regMatch(hz.rS2, hz.idUsesS2, exRw_r,  exRegWr_r);
    assign hitMem1_s = regMatch(hz.rS1, hz.idUsesS1, memRw_r, memRegWr_r);
    assign hitMem2_s = regMatch(hz.rS2, hz.idUsesS2, memRw_r, memRegWr_r);
    assign hitWb1_s  = regMatch(hz.rS1, hz.idUsesS1, wbRw_r,  wbRegWr_r);
    assign hitWb2_s  = regMatch(hz.rS2, hz.idUsesS2, wbRw_r,  wbRegWr_r);

    // Load result not ready for EX yet; store data (rS2) can take it later in MEM.
    assign loadUse_s       = exLoad_r && (hitEx1_s || (hitEx2_s && !hz.idStore));
    // Branch compares in ID, so an EX producer of busA can never be forwarded.
    assign branchEx_s      = hz.idBranch && hitEx1_s;
    // Load data in MEM is not available to the ID comparator.
    assign branchMemLoad_s = hz.idBranch && memLoad_r && (hitMem1_s || hitMem2_s);
    // No register-file write-through: a WB producer is invisible to the ID read.
    assign wbOnly_s        = (hitWb1_s && !hitEx1_s && !hitMem1_s) ||
                             (hitWb2_s && !hitEx2_s && !hitMem2_s);

    assign hazard_s     = loadUse_s || branchEx_s || branchMemLoad_s || wbOnly_s;
    assign run_s        = (state_r == RUN);
    assign stall_s      = run_s && hazard_s;
    assign flowing_s    = run_s && !hazard_s;
    assign acceptHalt_s = flowing_s && hz.idHalt;

    // ------------------------------------------------------------------
    // Flow control and forwarding selects
    // ------------------------------------------------------------------
    logic ifIdWrIn_s;
    logic pcWr_s;
    logic bubble_s;
    logic exMemIdA_s;
    logic exMemIdB_s;
    logic exMemExA_s;
    logic exMemExB_s;
    logic memWbExA_s;
    logic memWbExB_s;
    logic memWbMem_s;

    // Forward only while the ID instruction actually advances; otherwise hold and bubble.
    always_comb begin
        ifIdWrIn_s = 1'b1;
        pcWr_s     = 1'b1;
        bubble_s   = 1'b0;
        exMemIdA_s = 1'b0;
        exMemIdB_s = 1'b0;
        exMemExA_s = 1'b0;
        exMemExB_s = 1'b0;
        memWbExA_s = 1'b0;
        memWbExB_s = 1'b0;
        memWbMem_s = 1'b0;
        if (flowing_s) begin
            exMemExA_s = hitEx1_s && !exLoad_r;
            exMemExB_s = hitEx2_s && !exLoad_r;
            memWbExA_s = hitMem1_s && !exMemExA_s;
            memWbExB_s = hitMem2_s && !exMemExB_s;
            exMemIdA_s = hz.idBranch && hitMem1_s && !memLoad_r;
            exMemIdB_s = hz.idBranch && hitMem2_s && !memLoad_r;
            memWbMem_s = hz.idStore && hitEx2_s && exLoad_r;
        end else begin
            ifIdWrIn_s = 1'b0;
            pcWr_s     = 1'b0;
            bubble_s   = 1'b1;
        end
    end

    assign hz.ifIdWrIn    = ifIdWrIn_s;
    assign hz.pcWr        = pcWr_s;
    assign hz.bubble      = bubble_s;
    assign hz.exMemIdA    = exMemIdA_s;
    assign hz.exMemIdB    = exMemIdB_s;
    assign hz.exMemExA    = exMemExA_s;
    assign hz.exMemExB    = exMemExB_s;
    assign hz.memWbExA    = memWbExA_s;
    assign hz.memWbExB    = memWbExB_s;
    assign hz.memWbMem    = memWbMem_s;
    assign hz.endProgram  = endProgram_r;
    assign hz.stallCycles = stallCycles_r;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Shift producer tracking EX -> MEM -> WB; a bubble enters EX as all-zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            exRw_r     <= 5'd0;
            exRegWr_r  <= 1'b0;
            exLoad_r   <= 1'b0;
            memRw_r    <= 5'd0;
            memRegWr_r <= 1'b0;
            memLoad_r  <= 1'b0;
            wbRw_r     <= 5'd0;
            wbRegWr_r  <= 1'b0;
        end else begin
            wbRw_r     <= memRw_r;
            wbRegWr_r  <= memRegWr_r;
            memRw_r    <= exRw_r;
            memRegWr_r <= exRegWr_r;
            memLoad_r  <= exLoad_r;
            if (bubble_s) begin
                exRw_r    <= 5'd0;
                exRegWr_r <= 1'b0;
                exLoad_r  <= 1'b0;
            end else begin
                exRw_r    <= hz.idRw;
                exRegWr_r <= hz.idRegWr;
                exLoad_r  <= hz.idLoad;
            end
        end
    end

    // Halt sequencing: RUN until a non-stalled halt, DRAIN for DRAIN_CYCLES, then DONE until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= RUN;
            drainCnt_r   <= {CNT_W{1'b0}};
            endProgram_r <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    endProgram_r <= 1'b0;
                    if (acceptHalt_s) begin
                        state_r    <= DRAIN;
                        drainCnt_r <= DRAIN_LOAD;
                    end else begin
                        state_r    <= RUN;
                        drainCnt_r <= {CNT_W{1'b0}};
                    end
                end
                DRAIN: begin
                    if (drainCnt_r == {CNT_W{1'b0}}) begin
                        state_r      <= DONE;
                        endProgram_r <= 1'b1;
                    end else begin
                        state_r      <= DRAIN;
                        drainCnt_r   <= drainCnt_r - CNT_W'(1);
                        endProgram_r <= 1'b0;
                    end
                end
                DONE: begin
                    state_r      <= DONE;
                    endProgram_r <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: restart in RUN rather than freeze silently.
                    state_r      <= RUN;
                    drainCnt_r   <= {CNT_W{1'b0}};
                    endProgram_r <= 1'b0;
                end
            endcase
        end
    end

    // Count hazard-stall cycles while running, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCycles_r <= {STALL_CNT_W{1'b0}};
        end else if (stall_s && (stallCycles_r != {STALL_CNT_W{1'b1}})) begin
            stallCycles_r <= stallCycles_r + STALL_CNT_W'(1);
        end else begin
            stallCycles_r <= stallCycles_r;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed pipeline scenarios
// followed by randomized instruction streams, all checked every cycle against
// a history-based reference model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int DRAIN_CYCLES = 4;
    localparam int STALL_CNT_W  = 16;
    localparam int RAND_CYCLES  = 600;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pipeline_hazard_ctrl_if #(.STALL_CNT_W(STALL_CNT_W)) hz ();

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // age[d] = instruction that left ID d cycles ago (1=EX, 2=MEM, 3=WB).
    typedef struct packed {
        logic [4:0] rw;
        logic       wr;
        logic       ld;
    } prod_t;

    prod_t age [1:3];
    int    cyc;
    int    haltAt;
    int    stallCnt;
    logic  expHold;
    logic  expStall;
    logic  expAccept;

    task automatic modelReset();
        for (int d = 1; d <= 3; d++) age[d] = '0;
        cyc      = 0;
        haltAt   = -1;
        stallCnt = 0;
        expHold  = 1'b0;
        expStall = 1'b0;
        expAccept = 1'b0;
    endtask

    function automatic logic hit(input logic [4:0] src, input logic used, input int d);
        return used && age[d].wr && (age[d].rw != 5'd0) && (age[d].rw == src);
    endfunction

    // Distance to the youngest in-flight writer of src (0 = none).
    function automatic int youngest(input logic [4:0] src, input logic used);
        for (int d = 1; d <= 3; d++) begin
            if (hit(src, used, d)) return d;
        end
        return 0;
    endfunction

    task automatic setInstr(input logic [4:0] s1, input logic [4:0] s2, input logic u1, input logic u2,
                            input logic [4:0] rw, input logic wr, input logic ld, input logic st,
                            input logic br, input logic halt);
        hz.rS1 = s1; hz.rS2 = s2; hz.idUsesS1 = u1; hz.idUsesS2 = u2;
        hz.idRw = rw; hz.idRegWr = wr; hz.idLoad = ld; hz.idStore = st;
        hz.idBranch = br; hz.idHalt = halt;
    endtask

    task automatic setNop();
        setInstr(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Compare all outputs against the model, away from the active edge.
    task automatic sample();
        int   y1, y2;
        logic running, loadUse, brEx, brMem, wbOld;
        logic ex1, ex2, mw1, mw2, idA, idB, mem;
        logic expEnd;
        @(negedge clk);
        y1 = youngest(hz.rS1, hz.idUsesS1);
        y2 = youngest(hz.rS2, hz.idUsesS2);
        running = (haltAt < 0) || (cyc <= haltAt);
        loadUse = age[1].ld && ((y1 == 1) || ((y2 == 1) && !hz.idStore));
        brEx    = hz.idBranch && (y1 == 1);
        brMem   = hz.idBranch && age[2].ld &&
                  (hit(hz.rS1, hz.idUsesS1, 2) || hit(hz.rS2, hz.idUsesS2, 2));
        wbOld   = (y1 == 3) || (y2 == 3);
        expStall  = running && (loadUse || brEx || brMem || wbOld);
        expHold   = !running || expStall;
        expAccept = running && !expStall && hz.idHalt && (haltAt < 0);
        ex1 = (y1 == 1) && !age[1].ld;
        ex2 = (y2 == 1) && !age[1].ld;
        mw1 = hit(hz.rS1, hz.idUsesS1, 2) && !ex1;
        mw2 = hit(hz.rS2, hz.idUsesS2, 2) && !ex2;
        idA = hz.idBranch && hit(hz.rS1, hz.idUsesS1, 2) && !age[2].ld;
        idB = hz.idBranch && hit(hz.rS2, hz.idUsesS2, 2) && !age[2].ld;
        mem = hz.idStore && hit(hz.rS2, hz.idUsesS2, 1) && age[1].ld;
        if (expHold) begin
            {ex1, ex2, mw1, mw2, idA, idB, mem} = 7'd0;
        end
        expEnd = (haltAt >= 0) && (cyc >= haltAt + DRAIN_CYCLES + 1);
        checkVal("flowCtrl", {29'd0, hz.ifIdWrIn, hz.pcWr, hz.bubble},
                 {29'd0, !expHold, !expHold, expHold});
        checkVal("forwards", {25'd0, hz.exMemIdA, hz.exMemIdB, hz.exMemExA, hz.exMemExB,
                              hz.memWbExA, hz.memWbExB, hz.memWbMem},
                 {25'd0, idA, idB, ex1, ex2, mw1, mw2, mem});
        checkVal("endProgram", {31'd0, hz.endProgram}, {31'd0, expEnd});
        checkVal("stallCycles", {16'd0, hz.stallCycles}, stallCnt);
    endtask

    // Clock edge: advance the model by one instruction slot.
    task automatic advance();
        @(posedge clk);
        #1;
        if (reset) begin
            modelReset();
        end else begin
            if (expStall && (stallCnt < (1 << STALL_CNT_W) - 1)) stallCnt++;
            if (expAccept) haltAt = cyc;
            age[3] = age[2];
            age[2] = age[1];
            age[1] = expHold ? 7'd0 : {hz.idRw, hz.idRegWr, hz.idLoad};
            cyc++;
        end
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic flush();
        setNop();
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic randInstr();
        logic [4:0] a, b, w;
        logic       o;
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        w = 5'($urandom_range(0, 3));
        o = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
            0: setInstr(a, b, 1'b1, o, w, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);     // ALU
            1: setInstr(a, b, 1'b1, 1'b0, w, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // load
            2: setInstr(a, b, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // store
            3: setInstr(a, b, 1'b1, o, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);  // branch
            default: setInstr(a, b, o, 1'b0, w, o, 1'b0, 1'b0, 1'b0, 1'b0);  // misc
        endcase
    endtask

    int stallBase;

    initial begin
        modelReset();
        setNop();
        reset = 1'b1;
        advance();
        advance();
        sample();
        checkVal("rstIfIdWr", {31'd0, hz.ifIdWrIn}, 32'd1);
        checkVal("rstBubble", {31'd0, hz.bubble}, 32'd0);
        checkVal("rstStallCnt", {16'd0, hz.stallCycles}, 32'd0);
        reset = 1'b0;
        advance();
        flush();

        // ALU chain: add r3 ; sub r4,r3,r5 ; consumer of r3
        setInstr(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
        setInstr(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); sample();
        checkVal("aluChainExMemExA", {31'd0, hz.exMemExA}, 32'd1);
        checkVal("aluChainNoStall", {31'd0, hz.ifIdWrIn}, 32'd1);
        advance();
        setInstr(5'd3, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); sample();
        checkVal("aluChainMemWbExA", {31'd0, hz.memWbExA}, 32'd1);
        advance();
        flush();

        // Load-use: lw r2 ; add r6,r2,r7
        stallBase = stallCnt;
        setInstr(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
        setInstr(5'd2, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); sample();
        checkVal("loadUseHold", {29'd0, hz.ifIdWrIn, hz.pcWr, hz.bubble}, 32'd1);
        advance();
        sample();
        checkVal("loadUseMemWbExA", {31'd0, hz.memWbExA}, 32'd1);
        checkVal("loadUseStallInc", {16'd0, hz.stallCycles}, stallBase + 1);
        advance();
        flush();

        // Load -> store data: lw r2 ; sw r2,0(r1)
        setInstr(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
        setInstr(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); sample();
        checkVal("loadStoreMemWbMem", {31'd0, hz.memWbMem}, 32'd1);
        checkVal("loadStoreNoStall", {31'd0, hz.ifIdWrIn}, 32'd1);
        advance();
        flush();

        // Branch after load: lw r8 ; beq r8,r9 -> three stall cycles
        setInstr(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
        setInstr(5'd8, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            sample();
            checkVal($sformatf("brLoadStall%0d", k), {31'd0, hz.ifIdWrIn}, 32'd0);
            advance();
        end
        sample();
        checkVal("brLoadResume", {31'd0, hz.ifIdWrIn}, 32'd1);
        checkVal("brLoadNoFwd", {25'd0, hz.exMemIdA, hz.exMemIdB, hz.exMemExA, hz.exMemExB,
                                 hz.memWbExA, hz.memWbExB, hz.memWbMem}, 32'd0);
        advance();
        flush();

        // Branch after ALU: add r9 ; bnez r9
        setInstr(5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
        setInstr(5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); sample();
        checkVal("brAluStall", {31'd0, hz.pcWr}, 32'd0);
        advance();
        sample();
        checkVal("brAluExMemIdA", {31'd0, hz.exMemIdA}, 32'd1);
        advance();
        flush();

        // r0 is never a hazard: lw r0 ; use r0
        setInstr(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
        setInstr(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); sample();
        checkVal("r0NoStall", {31'd0, hz.ifIdWrIn}, 32'd1);
        advance();
        flush();

        // Randomized instruction stream; a stalled instruction stays in ID.
        for (int i = 0; i < RAND_CYCLES; i++) begin
            if (!expHold) randInstr();
            step();
        end
        flush();

        // Halt, then reset in the middle of the drain.
        setInstr(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        step();
        sample();
        reset = 1'b1;
        advance();
        reset = 1'b0;
        setNop();
        sample();
        checkVal("midDrainRstEnd", {31'd0, hz.endProgram}, 32'd0);
        checkVal("midDrainRstStall", {16'd0, hz.stallCycles}, 32'd0);
        checkVal("midDrainRstPcWr", {31'd0, hz.pcWr}, 32'd1);
        advance();

        // Full halt drain to endProgram, which then persists.
        setInstr(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        sample();
        checkVal("haltPcWrT", {31'd0, hz.pcWr}, 32'd1);
        advance();
        for (int k = 1; k <= DRAIN_CYCLES + 3; k++) begin
            sample();
            checkVal($sformatf("haltPcWr%0d", k), {31'd0, hz.pcWr}, 32'd0);
            checkVal($sformatf("haltEnd%0d", k), {31'd0, hz.endProgram},
                     (k >= DRAIN_CYCLES + 1) ? 32'd1 : 32'd0);
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and forwarding controller for the 5-stage pipeline datapath (IF/ID/EX/MEM/WB). It tracks the destination register and write/load flags of the instructions in EX, MEM and WB. It drives the datapath's forwarding mux selects and the IF/ID write enable, inserts bubbles into ID/EX on stalls, and sequences the end-of-program drain that raises endProgram. It sits beside the decoder. Its forwarding outputs for EX/MEM are computed in ID and packed into the exCtrl/memCtrl words that ID/EX latches.

Parameters:
DRAIN_CYCLES, 4, cycles to wait after a halt enters ID before asserting endProgram (EX, MEM and WB retire, plus the data-memory write settles)
STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
rS1  in  5  ID source register 1
rS2  in  5  ID source register 2
idUsesS1  in  1  ID instruction reads rS1
idUsesS2  in  1  ID instruction reads rS2
idRw  in  5  ID destination (post REG_DST/link mux, i.e. rWOut)
idRegWr  in  1  ID instruction writes a register
idLoad  in  1  ID instruction is a load
idStore  in  1  ID instruction is a store (rS2 is store data only)
idBranch  in  1  ID instruction compares busA in ID
idHalt  in  1  ID instruction is the program-end marker
exMemIdA  out  1  idCtrl[1]: busA <- aluResultMem
exMemIdB  out  1  idCtrl[2]: busB <- aluResultMem
exMemExA  out  1  to exCtrl[3]
exMemExB  out  1  to exCtrl[4]
memWbExA  out  1  to exCtrl[5]
memWbExB  out  1  to exCtrl[6]
memWbMem  out  1  to memCtrl[4]
ifIdWrIn  out  1  IF/ID write enable (0 = hold)
pcWr  out  1  PC update enable
bubble  out  1  decoder zeroes aluCtrl/exCtrl/memCtrl/wrCtrl into ID/EX
endProgram  out  1  program finished, held until reset
stallCycles  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- Tracking registers:
  - (exRw, exRegWr, exLoad), (memRw, memRegWr, memLoad), (wbRw, wbRegWr).
  - They shift EX->MEM->WB every clock. EX loads the ID fields, or zeros when bubble=1.
  - Register 0 is never a hazard: a match requires Rw != 0 and RegWr = 1.
- Register file has no write-through. A producer in WB is invisible to an ID read in the same cycle.
- Match definitions, for src in {rS1, rS2} with the matching uses bit:
  - hitEX: src == exRw
  - hitMEM: src == memRw
  - hitWB: src == wbRw
- Stall (combinational, same cycle). Stall is asserted if any of the following hold:
  - (a) load-use: hitEX with exLoad, unless the only such use is rS2 of a store.
  - (b) branch operand rS1 with hitEX, any type.
  - (c) branch operand with hitMEM and memLoad.
  - (d) any used source with hitWB and no younger hitEX/hitMEM on the same source.
- During a stall: ifIdWrIn=0, pcWr=0, bubble=1, and all forwarding outputs are 0.
- EX-stage forwarding outputs (computed in ID, only when not stalling):
  - exMemExX = hitEX, producer not a load.
  - memWbExX = hitMEM and not exMemExX (youngest producer wins).
- ID forwarding: exMemIdA/B = idBranch and hitMEM and not memLoad.
- Store data: memWbMem = idStore and rS2 hitEX and exLoad. No stall, exMemExB=0.
- Halt sequence (FSM RUN -> DRAIN -> DONE):
  - RUN: idHalt=1 with no stall -> DRAIN, counter = DRAIN_CYCLES-1. A halt that is stalled waits in RUN.
  - DRAIN: ifIdWrIn=0, pcWr=0, bubble=1. Decrement the counter each cycle; at 0 -> DONE.
  - DONE: endProgram=1 and the DRAIN outputs persist. Stays in DONE until reset.
  - Hazard stalls are ignored outside RUN.
- stallCycles: increments on each RUN cycle with stall=1 and saturates at all-ones.
- Reset (synchronous, wins over everything, including mid-drain):
  - All tracking regs 0, FSM RUN, stallCycles 0, endProgram 0.
  - With cleared tracking: ifIdWrIn=1, pcWr=1, bubble=0, all forwards 0.

Test Plan:
- ALU chain: add r3 in ID at T, then sub r4,r3,r5 in ID at T+1 -> exMemExA=1 at T+1, no stall. The next consumer of r3, at T+2, gets memWbExA=1.
- Load-use: lw r2 in ID at T, then add r6,r2,r7 in ID at T+1 -> at T+1: ifIdWrIn=0, pcWr=0, bubble=1. At T+2: memWbExA=1. stallCycles increments by 1.
- Load->store: lw r2 at T, then sw r2 at T+1 -> memWbMem=1, ifIdWrIn=1, no stall.
- Branch after load: lw r8 at T, then beq on r8 at T+1 -> stalls at T+1, T+2 and T+3 (EX, MEM and WB cases). Resumes at T+4 with all forwards 0.
- Branch after ALU: add r9 at T, then bnez r9 at T+1 -> stall at T+1, exMemIdA=1 at T+2.
- Halt/reset: idHalt at T -> pcWr=0 from T+1, endProgram=1 at T+DRAIN_CYCLES+1. Asserting reset at T+2 instead returns FSM to RUN with endProgram=0 and stallCycles=0. Writes to r0 never stall.
